exec_column_sequencer: RTL and testbench

//  Sequences the 4-lane execute stage for column-wise matrix ops.

---
 rtl/exec_column_sequencer.sv | 113 +++++++++++
 tb/tb_exec_column_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_column_sequencer.sv
// Column-pass sequencer for the 4-lane execute stage: steps the ALU column
// index across NUM_COLS passes and holds the front end until the final pass.
module exec_column_sequencer #(
  parameter int          NUM_COLS   = 4,
  parameter logic [15:0] MULTI_MASK = 16'h00C0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       aluControl,
  input  logic             stop,
  input  logic             flush,
  output logic [1:0]       column,
  output logic             stall,
  output logic             col_valid,
  output logic             last_pass,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic       multi;
  logic       accept;
  logic       count_en;

  assign multi  = MULTI_MASK[aluControl];
  assign accept = op_valid & ~stop & ~flush;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    state_d   = state_q;
    col_d     = col_q;
    column    = 2'd0;
    stall     = 1'b0;
    col_valid = 1'b0;
    last_pass = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The accepting cycle is itself pass 0 of the op.
        col_valid = accept;
        if (accept) begin
          if (multi) begin
            stall   = 1'b1;
            state_d = RUN;
            col_d   = 2'd1;
          end else begin
            last_pass = 1'b1;
          end
        end
      end
      RUN: begin
        busy      = 1'b1;
        column    = col_q;
        col_valid = ~stop & ~flush;
        if (col_q == LAST_COL) begin
          // Stall drops on the final pass so the next op enters EX with no bubble.
          last_pass = ~stop & ~flush;
          if (!stop) begin
            state_d = IDLE;
            col_d   = 2'd0;
          end
        end else begin
          // Stall keeps its value under stop: the pipeline is already frozen.
          stall = 1'b1;
          if (!stop) col_d = col_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      col_d   = 2'd0;
      stall   = 1'b0;
    end

    // Outputs are forced quiet for the whole time reset is asserted.
    if (!rst) begin
      column    = 2'd0;
      stall     = 1'b0;
      col_valid = 1'b0;
      last_pass = 1'b0;
      busy      = 1'b0;
    end
  end

  assign count_en = col_valid & last_pass;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      col_q    <= 2'd0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (count_en && (op_count != {CNT_W{1'b1}}))
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_column_sequencer.sv
// Self-checking bench for exec_column_sequencer: directed scenarios followed by
// randomized traffic compared against a pass-level behavioural model.
module tb_exec_column_sequencer;

  localparam int          NUM_COLS = 4;
  localparam logic [15:0] MASK     = 16'h00C0;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  alu;
  logic        stop;
  logic        flush;

  logic [1:0]  column;
  logic        stall, col_valid, last_pass, busy;
  logic [15:0] op_count;

  logic [1:0]  s_column;
  logic        s_stall, s_col_valid, s_last_pass, s_busy;
  logic [3:0]  s_op_count;

  logic [5:0]  obs;
  assign obs = {column, stall, col_valid, last_pass, busy};

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  exec_column_sequencer #(.NUM_COLS(NUM_COLS), .MULTI_MASK(MASK), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .aluControl(alu), .stop(stop),
    .flush(flush), .column(column), .stall(stall), .col_valid(col_valid),
    .last_pass(last_pass), .busy(busy), .op_count(op_count)
  );

  exec_column_sequencer #(.NUM_COLS(NUM_COLS), .MULTI_MASK(MASK), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .op_valid(op_valid), .aluControl(alu), .stop(stop),
    .flush(flush), .column(s_column), .stall(s_stall), .col_valid(s_col_valid),
    .last_pass(s_last_pass), .busy(s_busy), .op_count(s_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vectors are {column, stall, col_valid, last_pass, busy}.
  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b1; alu = 4'd6; stop = 1'b0; flush = 1'b0;
    #2;
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0);
    end
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL reset_outputs_held: got %b expected %b", obs, 6'b0);
    end
    checks++;
    if (op_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", op_count);
    end
    op_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_multi();
    logic [5:0] exp [4] = '{6'b00_1_1_0_0, 6'b01_1_1_0_1, 6'b10_1_1_0_1, 6'b11_0_1_1_1};
    op_valid = 1'b1; alu = 4'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL multi_pass%0d: got %b expected %b", i, obs, exp[i]);
      end
      tick();
    end
    op_valid = 1'b0;
    exp_count = 1;
    @(negedge clk);
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++; $display("FAIL multi_count: got %0d expected %0d", op_count, exp_count);
    end
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL multi_idle_after: got %b expected %b", obs, 6'b0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp [5] = '{6'b00_1_1_0_0, 6'b01_1_1_0_1, 6'b10_1_1_0_1, 6'b11_0_1_1_1,
                            6'b00_0_1_1_0};
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu = (i == 4) ? 4'd2 : 4'd6;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs, exp[i]);
      end
      tick();
    end
    op_valid = 1'b0;
    exp_count += 2;
    @(negedge clk);
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", op_count, exp_count);
    end
    tick();
  endtask

  task automatic test_stop();
    logic [5:0] exp [6] = '{6'b00_1_1_0_0, 6'b01_1_0_0_1, 6'b01_1_0_0_1, 6'b01_1_1_0_1,
                            6'b10_1_1_0_1, 6'b11_0_1_1_1};
    for (int i = 0; i < 6; i++) begin
      // After acceptance, op_valid/aluControl carry a different op that must be ignored.
      op_valid = 1'b1;
      alu      = (i == 0) ? 4'd7 : 4'd2;
      stop     = (i == 1 || i == 2);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL stop_cycle%0d: got %b expected %b", i, obs, exp[i]);
      end
      tick();
    end
    op_valid = 1'b0; stop = 1'b0;
    exp_count += 1;
    @(negedge clk);
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++; $display("FAIL stop_count: got %0d expected %0d", op_count, exp_count);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [5:0] exp [4] = '{6'b00_1_1_0_0, 6'b01_1_1_0_1, 6'b10_0_0_0_1, 6'b00_0_1_1_0};
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1;
      alu      = (i < 2) ? 4'd6 : 4'd2;
      flush    = (i == 2);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL flush_cycle%0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i == 3) begin
        checks++;
        if (op_count !== 16'(exp_count)) begin
          errors++; $display("FAIL flush_not_counted: got %0d expected %0d", op_count, exp_count);
        end
      end
      tick();
    end
    op_valid = 1'b0; flush = 1'b0;
    exp_count += 1;
    @(negedge clk);
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++; $display("FAIL flush_count: got %0d expected %0d", op_count, exp_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    op_valid = 1'b1; alu = 4'd6;
    tick();
    op_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (obs !== 6'b10_1_1_0_1) begin
      errors++; $display("FAIL areset_pre: got %b expected %b", obs, 6'b10_1_1_0_1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL areset_outputs: got %b expected %b", obs, 6'b0);
    end
    checks++;
    if (op_count !== 16'd0 || s_op_count !== 4'd0) begin
      errors++; $display("FAIL areset_count: got %0d/%0d expected 0/0", op_count, s_op_count);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL areset_idle: got %b expected %b", obs, 6'b0);
    end
    exp_count = 0;
    tick();
  endtask

  task automatic test_saturation();
    op_valid = 1'b1; alu = 4'd2;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 14 || i == 15 || i == 16) begin
        checks++;
        if (s_op_count !== 4'(i > 15 ? 15 : i)) begin
          errors++; $display("FAIL sat_count_after%0d: got %0d expected %0d", i, s_op_count,
                             (i > 15 ? 15 : i));
        end
      end
    end
    op_valid = 1'b0;
    #1;
    checks++;
    if (s_op_count !== 4'hF) begin
      errors++; $display("FAIL sat_final: got %0d expected 15", s_op_count);
    end
    checks++;
    if (op_count !== 16'd17) begin
      errors++; $display("FAIL sat_wide_count: got %0d expected 17", op_count);
    end
    tick();
  endtask

  // Model tracks the op by pass number: 0 means no multi op in flight.
  task automatic test_random();
    int         pass = 0;
    int         cnt  = 0;
    bit         multi, accept;
    logic [5:0] exp;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int n = 0; n < 500; n++) begin
      op_valid = ($urandom_range(3) != 0);
      alu      = ($urandom_range(1) == 1) ? 4'($urandom_range(6, 7)) : 4'($urandom_range(15));
      stop     = ($urandom_range(7) == 0);
      flush    = ($urandom_range(15) == 0);
      multi    = MASK[alu];
      if (pass == 0) begin
        accept = op_valid && !stop && !flush;
        exp = {2'd0, accept && multi, accept, accept && !multi, 1'b0};
      end else begin
        accept = !stop && !flush;
        exp = {2'(pass), !flush && (pass < NUM_COLS - 1), accept,
               accept && (pass == NUM_COLS - 1), 1'b1};
      end
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_outputs cycle%0d: got %b expected %b (pass=%0d ov=%b alu=%0d stop=%b flush=%b)",
                 n, obs, exp, pass, op_valid, alu, stop, flush);
      end
      checks++;
      if (op_count !== 16'(cnt) || s_op_count !== 4'(cnt > 15 ? 15 : cnt)) begin
        errors++;
        $display("FAIL random_count cycle%0d: got %0d/%0d expected %0d", n, op_count,
                 s_op_count, cnt);
      end
      @(posedge clk);
      if (exp[1]) cnt++;
      if (flush)                     pass = 0;
      else if (stop)                 pass = pass;
      else if (pass == 0)            pass = (op_valid && multi) ? 1 : 0;
      else if (pass == NUM_COLS - 1) pass = 0;
      else                           pass = pass + 1;
      #1;
    end
    op_valid = 1'b0; stop = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_multi();
    test_back_to_back();
    test_stop();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
